// File: rtl/pc_sequencer_if.sv
// Bundle of control-flow inputs, instruction-fetch handshake and status outputs
// exchanged between the PC sequencer and its surroundings.
interface pc_sequencer_if;
    logic        branch1;
    logic        branch2;
    logic        zero_bit;
    logic [31:0] jump_pc;
    logic [31:0] alu_result;
    logic        ctrl_valid;
    logic        stall;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        flush;
    logic        misalign_err;
    logic [31:0] retire_count;

    modport master (
        input  branch1,
        input  branch2,
        input  zero_bit,
        input  jump_pc,
        input  alu_result,
        input  ctrl_valid,
        input  stall,
        input  imem_ack,
        output imem_req,
        output imem_addr,
        output pc,
        output flush,
        output misalign_err,
        output retire_count
    );

    modport slave (
        output branch1,
        output branch2,
        output zero_bit,
        output jump_pc,
        output alu_result,
        output ctrl_valid,
        output stall,
        output imem_ack,
        input  imem_req,
        input  imem_addr,
        input  pc,
        input  flush,
        input  misalign_err,
        input  retire_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, target selection, redirect flush
// and sticky misalignment halt. All outputs come straight from registers.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] retire_count_r;
    logic        flush_r;
    logic        misalign_err_r;
    logic        imem_req_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        fire_s;
    logic        misalign_s;
    logic        update_s;

    // Target selection from the branch code; redirect marks every non-sequential path.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        target_s   = pc_plus4_s;
        redirect_s = 1'b0;
        case ({bus.branch2, bus.branch1})
            2'b00: begin
                target_s   = pc_plus4_s;
                redirect_s = 1'b0;
            end
            2'b01: begin
                target_s   = bus.jump_pc;
                redirect_s = 1'b1;
            end
            2'b10: begin
                target_s   = {bus.alu_result[31:1], 1'b0};
                redirect_s = 1'b1;
            end
            2'b11: begin
                if (bus.zero_bit) begin
                    target_s   = bus.jump_pc;
                    redirect_s = 1'b1;
                end else begin
                    target_s   = pc_plus4_s;
                    redirect_s = 1'b0;
                end
            end
            default: begin
                target_s   = pc_plus4_s;
                redirect_s = 1'b0;
            end
        endcase
    end

    // Qualified update event and its alignment outcome.
    always_comb begin
        fire_s     = (state_r == EXEC) && bus.ctrl_valid && !bus.stall;
        misalign_s = redirect_s && (target_s[1:0] != 2'b00);
        update_s   = fire_s && !misalign_s;
    end

    // Next-state logic for the fetch/execute sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = FETCH;
                end
            end
            EXEC: begin
                if (fire_s) begin
                    if (misalign_s) begin
                        state_next_s = HALT;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = EXEC;
                end
            end
            HALT: begin
                state_next_s = HALT;
            end
            default: begin
                state_next_s = BOOT;
            end
        endcase
    end

    // State register; the fetch request is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= BOOT;
            imem_req_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            imem_req_r <= (state_next_s == FETCH);
        end
    end

    // Architectural state: pc, retire counter, flush pulse and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r           <= RESET_PC;
            retire_count_r <= 32'd0;
            flush_r        <= 1'b0;
            misalign_err_r <= 1'b0;
        end else begin
            flush_r <= update_s && redirect_s;
            if (update_s) begin
                pc_r           <= target_s;
                retire_count_r <= retire_count_r + 32'd1;
            end
            if (fire_s && misalign_s) begin
                misalign_err_r <= 1'b1;
            end
        end
    end

    assign bus.imem_req     = imem_req_r;
    assign bus.imem_addr    = pc_r;
    assign bus.pc           = pc_r;
    assign bus.flush        = flush_r;
    assign bus.misalign_err = misalign_err_r;
    assign bus.retire_count = retire_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random stimulus, all
// checked cycle by cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0=boot 1=fetch 2=exec 3=halt
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_flush;
    logic        m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int          code;
        logic        taken;
        logic [31:0] tgt;
        code    = {bus.branch2, bus.branch1};
        m_flush = 1'b0;
        if (reset) begin
            m_phase = 0;
            m_pc    = RST_PC;
            m_ret   = 32'd0;
            m_err   = 1'b0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (bus.imem_ack) m_phase = 2;
        end else if (m_phase == 2) begin
            if (bus.ctrl_valid && !bus.stall) begin
                taken = (code == 1) || (code == 2) || (code == 3 && bus.zero_bit);
                if (code == 2)  tgt = bus.alu_result - (bus.alu_result % 32'd2);
                else if (taken) tgt = bus.jump_pc;
                else            tgt = m_pc + 32'd4;
                if (taken && (tgt % 32'd4) != 32'd0) begin
                    m_err   = 1'b1;
                    m_phase = 3;
                end else begin
                    m_pc    = tgt;
                    m_ret   = m_ret + 32'd1;
                    m_flush = taken;
                    m_phase = 1;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_eq("pc", bus.pc, m_pc);
        check_eq("imem_addr", bus.imem_addr, m_pc);
        check_eq("imem_req", {31'd0, bus.imem_req}, {31'd0, (m_phase == 1)});
        check_eq("flush", {31'd0, bus.flush}, {31'd0, m_flush});
        check_eq("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
        check_eq("retire_count", bus.retire_count, m_ret);
    endtask

    task automatic do_fetch();
        bus.imem_ack = 1'b1;
        cyc();
        bus.imem_ack = 1'b0;
    endtask

    task automatic do_exec(input logic [1:0] code, input logic z,
                           input logic [31:0] jpc, input logic [31:0] alu);
        bus.branch2    = code[1];
        bus.branch1    = code[0];
        bus.zero_bit   = z;
        bus.jump_pc    = jpc;
        bus.alu_result = alu;
        bus.ctrl_valid = 1'b1;
        cyc();
        bus.ctrl_valid = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        m_phase        = 0;
        m_pc           = RST_PC;
        m_ret          = 32'd0;
        m_flush        = 1'b0;
        m_err          = 1'b0;
        bus.branch1    = 1'b0;
        bus.branch2    = 1'b0;
        bus.zero_bit   = 1'b0;
        bus.jump_pc    = 32'd0;
        bus.alu_result = 32'd0;
        bus.ctrl_valid = 1'b0;
        bus.stall      = 1'b0;
        bus.imem_ack   = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        check_eq("rst_pc", bus.pc, 32'h0);
        check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("rst_ret", bus.retire_count, 32'd0);

        reset = 1'b0;
        cyc();
        check_eq("boot_to_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        do_fetch();
        check_eq("exec_req", {31'd0, bus.imem_req}, 32'd0);
        do_exec(2'b00, 1'b0, 32'h0, 32'h0);
        check_eq("seq_pc", bus.pc, 32'h4);
        check_eq("seq_flush", {31'd0, bus.flush}, 32'd0);
        check_eq("seq_ret", bus.retire_count, 32'd1);

        do_fetch();
        do_exec(2'b01, 1'b0, 32'h100, 32'h0);
        do_fetch();
        do_exec(2'b01, 1'b0, 32'h200, 32'h0);
        check_eq("jal_pc", bus.pc, 32'h200);
        check_eq("jal_flush", {31'd0, bus.flush}, 32'd1);
        cyc();
        check_eq("jal_addr", bus.imem_addr, 32'h200);
        check_eq("jal_flush_end", {31'd0, bus.flush}, 32'd0);

        do_fetch();
        do_exec(2'b10, 1'b0, 32'h0, 32'h301);
        check_eq("jalr_pc", bus.pc, 32'h300);
        do_fetch();
        do_exec(2'b11, 1'b0, 32'h40, 32'h0);
        check_eq("bnt_pc", bus.pc, 32'h304);
        check_eq("bnt_flush", {31'd0, bus.flush}, 32'd0);
        do_fetch();
        do_exec(2'b11, 1'b1, 32'h40, 32'h0);
        check_eq("bt_pc", bus.pc, 32'h40);
        check_eq("bt_flush", {31'd0, bus.flush}, 32'd1);

        do_fetch();
        bus.stall = 1'b1;
        bus.ctrl_valid = 1'b1;
        bus.branch1 = 1'b0;
        bus.branch2 = 1'b0;
        repeat (3) cyc();
        check_eq("stall_pc", bus.pc, 32'h40);
        check_eq("stall_ret", bus.retire_count, 32'd6);
        bus.stall = 1'b0;
        cyc();
        bus.ctrl_valid = 1'b0;
        check_eq("unstall_pc", bus.pc, 32'h44);
        check_eq("unstall_ret", bus.retire_count, 32'd7);

        do_fetch();
        do_exec(2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0);
        do_fetch();
        do_exec(2'b00, 1'b0, 32'h0, 32'h0);
        check_eq("wrap_pc", bus.pc, 32'h0);
        check_eq("wrap_err", {31'd0, bus.misalign_err}, 32'd0);

        do_fetch();
        do_exec(2'b01, 1'b0, 32'h4, 32'h0);
        check_eq("same_tgt_flush", {31'd0, bus.flush}, 32'd1);

        do_fetch();
        do_exec(2'b10, 1'b0, 32'h0, 32'h302);
        check_eq("mis_err", {31'd0, bus.misalign_err}, 32'd1);
        check_eq("mis_pc", bus.pc, 32'h4);
        check_eq("mis_flush", {31'd0, bus.flush}, 32'd0);
        bus.imem_ack = 1'b1;
        bus.ctrl_valid = 1'b1;
        repeat (3) cyc();
        bus.imem_ack = 1'b0;
        bus.ctrl_valid = 1'b0;
        check_eq("halt_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("halt_pc", bus.pc, 32'h4);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        do_fetch();
        do_exec(2'b00, 1'b0, 32'h0, 32'h0);
        check_eq("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
        reset = 1'b1;
        bus.imem_ack = 1'b1;
        cyc();
        reset = 1'b0;
        bus.imem_ack = 1'b0;
        check_eq("fetch_rst_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("fetch_rst_pc", bus.pc, RST_PC);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] j;
            j = $urandom;
            if ($urandom_range(9, 0) != 0) j[1:0] = 2'b00;
            bus.jump_pc    = j;
            bus.alu_result = $urandom;
            bus.branch1    = 1'($urandom_range(1, 0));
            bus.branch2    = 1'($urandom_range(1, 0));
            bus.zero_bit   = 1'($urandom_range(1, 0));
            bus.ctrl_valid = ($urandom_range(2, 0) != 0);
            bus.stall      = ($urandom_range(3, 0) == 0);
            bus.imem_ack   = ($urandom_range(2, 0) != 0);
            reset          = ($urandom_range(m_phase == 3 ? 7 : 199, 0) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
